// File: rtl/conv_pkg.sv
// Shared types and helpers for the frame scheduler: FSM state encoding,
// a constant clog2 and the default frame geometry.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold v distinct values; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_K     = 3;
  localparam int unsigned OUT_DIM   = DEF_N - DEF_K + 1;
  localparam int unsigned PIX_TOTAL = DEF_N * DEF_N;

endpackage

// File: rtl/conv_pos_cnt.sv
// Raster row/column counter for an N x N frame; eof marks the last pixel.
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter  int unsigned N = 16,
  localparam int unsigned W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         eof
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign eof = (row == LAST) && (col == LAST);

endmodule

// File: rtl/conv_frame_sched.sv
// Frame scheduler: walks one N x N frame out of the image BRAM, drives the
// convolutor enable and tags every result that comes from a fully-inside window.
module conv_frame_sched
  import conv_pkg::*;
#(
  parameter  int unsigned N        = 16,
  parameter  int unsigned K_SIZE   = 3,
  parameter  int unsigned ADDR_W   = 14,
  parameter  int unsigned CONV_LAT = 1,
  localparam int unsigned OUT_D    = N - K_SIZE + 1,
  localparam int unsigned RC_W     = clog2(OUT_D),
  localparam int unsigned OA_W     = clog2(OUT_D * OUT_D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              conv_en_o,
  output logic              out_valid_o,
  output logic [RC_W-1:0]   out_row_o,
  output logic [RC_W-1:0]   out_col_o,
  output logic [OA_W-1:0]   out_addr_o
);

  localparam int unsigned PW = clog2(N);
  localparam int unsigned DW = clog2(CONV_LAT + 1);

  state_t state, state_nx;

  logic          accept;
  logic          kill;
  logic [PW-1:0] pix_row;
  logic [PW-1:0] pix_col;
  logic          pix_eof;
  logic [DW-1:0] drain_cnt;
  logic          win_ok;
  logic [RC_W-1:0] tag_row;
  logic [RC_W-1:0] tag_col;

  logic            vld_sr [0:CONV_LAT];
  logic [RC_W-1:0] row_sr [0:CONV_LAT];
  logic [RC_W-1:0] col_sr [0:CONV_LAT];

  assign accept = (state == ST_IDLE) && start_i;
  assign kill   = abort_i && ((state == ST_FETCH) || (state == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start_i) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (abort_i)      state_nx = ST_IDLE;
        else if (pix_eof) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i)                      state_nx = ST_IDLE;
        else if (drain_cnt == DW'(CONV_LAT)) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  conv_pos_cnt #(
    .N (N)
  ) u_pix_pos (
    .clk (clk),
    .rst (rst),
    .clr (accept || kill),
    .en  (state == ST_FETCH),
    .row (pix_row),
    .col (pix_col),
    .eof (pix_eof)
  );

  // DRAIN lasts 1+CONV_LAT cycles: BRAM read latency plus convolutor latency.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_DRAIN)) drain_cnt <= '0;
    else                            drain_cnt <= drain_cnt + 1'b1;
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      busy_o   <= (state_nx == ST_FETCH) || (state_nx == ST_DRAIN);
      done_o   <= (state_nx == ST_DONE);
      mem_en_o <= (state_nx == ST_FETCH);
      if (accept)                  mem_addr_o <= base_addr_i;
      else if (state == ST_FETCH)  mem_addr_o <= mem_addr_o + 1'b1;
    end
  end

  always_comb begin
    win_ok  = (pix_row >= PW'(K_SIZE - 1)) && (pix_col >= PW'(K_SIZE - 1));
    tag_row = '0;
    tag_col = '0;
    if (win_ok) begin
      tag_row = RC_W'(pix_row - PW'(K_SIZE - 1));
      tag_col = RC_W'(pix_col - PW'(K_SIZE - 1));
    end
  end

  // Stage 0 is the cycle the pixel sits on BRAM douta; stage CONV_LAT is the result.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      conv_en_o <= 1'b0;
      for (int unsigned i = 0; i <= CONV_LAT; i++) begin
        vld_sr[i] <= 1'b0;
        row_sr[i] <= '0;
        col_sr[i] <= '0;
      end
    end else begin
      conv_en_o <= mem_en_o;
      vld_sr[0] <= mem_en_o && win_ok;
      row_sr[0] <= tag_row;
      col_sr[0] <= tag_col;
      for (int unsigned i = 1; i <= CONV_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        row_sr[i] <= row_sr[i-1];
        col_sr[i] <= col_sr[i-1];
      end
    end
  end

  assign out_valid_o = vld_sr[CONV_LAT];
  assign out_row_o   = row_sr[CONV_LAT];
  assign out_col_o   = col_sr[CONV_LAT];

  always_ff @(posedge clk) begin
    if (rst || accept || kill) out_addr_o <= '0;
    else if (out_valid_o)      out_addr_o <= out_addr_o + 1'b1;
  end

endmodule
